// File: rtl/lc4_decode_stage_pkg.sv
// lc4_pkg: shared definitions for the LC4 decode stage.
//   - opcode constants for insn[15:12]
//   - stall codes carried alongside each instruction through the pipe
//   - decode_t: register selects, enables and class flags from the decoder
//   - squash(): clears every enable/flag so a slot has no side effects
package lc4_pkg;

  localparam logic [3:0] OP_BR      = 4'h0;
  localparam logic [3:0] OP_ARITH   = 4'h1;
  localparam logic [3:0] OP_CMP     = 4'h2;
  localparam logic [3:0] OP_JSR     = 4'h4;
  localparam logic [3:0] OP_LOGIC   = 4'h5;
  localparam logic [3:0] OP_LDR     = 4'h6;
  localparam logic [3:0] OP_STR     = 4'h7;
  localparam logic [3:0] OP_RTI     = 4'h8;
  localparam logic [3:0] OP_CONST   = 4'h9;
  localparam logic [3:0] OP_SHIFT   = 4'hA;
  localparam logic [3:0] OP_JMP     = 4'hC;
  localparam logic [3:0] OP_HICONST = 4'hD;
  localparam logic [3:0] OP_TRAP    = 4'hF;

  localparam logic [1:0] STALL_NONE  = 2'd0;
  localparam logic [1:0] STALL_FLUSH = 2'd2;
  localparam logic [1:0] STALL_LOAD  = 2'd3;

  typedef struct packed {
    logic [2:0] r1sel;
    logic [2:0] r2sel;
    logic [2:0] wsel;
    logic       r1re;
    logic       r2re;
    logic       regfile_we;
    logic       nzp_we;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_control;
  } decode_t;

  // Selects are left intact; only the fields that cause architectural
  // effects or hazards are cleared.
  function automatic decode_t squash(input decode_t d);
    decode_t s;
    s            = d;
    s.r1re       = 1'b0;
    s.r2re       = 1'b0;
    s.regfile_we = 1'b0;
    s.nzp_we     = 1'b0;
    s.is_load    = 1'b0;
    s.is_store   = 1'b0;
    s.is_branch  = 1'b0;
    s.is_control = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/lc4_decode_stage_decoder.sv
// lc4_decoder: purely combinational LC4 instruction decoder.
// Ports:
//   insn  in  16        instruction to decode
//   dec   out decode_t  register selects, enables and class flags
// Field positions: rd/rt-store [11:9], rs [8:6], rt [2:0].
// Undefined opcodes (0011, 1011, 1110) decode with every enable low.
module lc4_decoder
  import lc4_pkg::*;
(
  input  logic [15:0] insn,
  output decode_t     dec
);

  always_comb begin
    dec       = '0;
    dec.r1sel = insn[8:6];
    dec.r2sel = insn[2:0];
    dec.wsel  = insn[11:9];
    case (insn[15:12])
      OP_BR: begin
        // nzp=000 is the canonical NOP and is not a branch.
        dec.is_branch = (insn[11:9] != 3'b000);
      end
      OP_ARITH: begin
        // insn[5]=1 is ADDI (immediate form, no rt).
        dec.r1re       = 1'b1;
        dec.r2re       = ~insn[5];
        dec.regfile_we = 1'b1;
        dec.nzp_we     = 1'b1;
      end
      OP_CMP: begin
        // Compares only set nzp; source rs sits in [11:9].
        // insn[8]=1 selects the immediate forms CMPI/CMPIU.
        dec.r1sel  = insn[11:9];
        dec.r1re   = 1'b1;
        dec.r2re   = ~insn[8];
        dec.nzp_we = 1'b1;
      end
      OP_JSR: begin
        // insn[11]=0 is JSRR, which jumps through rs.
        dec.r1re       = ~insn[11];
        dec.wsel       = 3'd7;
        dec.regfile_we = 1'b1;
        dec.nzp_we     = 1'b1;
        dec.is_control = 1'b1;
      end
      OP_LOGIC: begin
        // NOT (001) and ANDI (1xx) have no rt operand.
        dec.r1re       = 1'b1;
        dec.r2re       = ~insn[5] & (insn[5:3] != 3'b001);
        dec.regfile_we = 1'b1;
        dec.nzp_we     = 1'b1;
      end
      OP_LDR: begin
        dec.r1re       = 1'b1;
        dec.regfile_we = 1'b1;
        dec.nzp_we     = 1'b1;
        dec.is_load    = 1'b1;
      end
      OP_STR: begin
        // r1 = base address (rs), r2 = store data (rt in [11:9]).
        dec.r2sel    = insn[11:9];
        dec.r1re     = 1'b1;
        dec.r2re     = 1'b1;
        dec.is_store = 1'b1;
      end
      OP_RTI: begin
        dec.r1sel      = 3'd7;
        dec.r1re       = 1'b1;
        dec.is_control = 1'b1;
      end
      OP_CONST: begin
        dec.regfile_we = 1'b1;
        dec.nzp_we     = 1'b1;
      end
      OP_SHIFT: begin
        // Only MOD (11) takes a register rt; shifts use an immediate.
        dec.r1re       = 1'b1;
        dec.r2re       = (insn[5:4] == 2'b11);
        dec.regfile_we = 1'b1;
        dec.nzp_we     = 1'b1;
      end
      OP_JMP: begin
        // insn[11]=0 is JMPR, which jumps through rs.
        dec.r1re       = ~insn[11];
        dec.is_control = 1'b1;
      end
      OP_HICONST: begin
        // HICONST keeps the low byte of rd, so rd is also a source.
        dec.r1sel      = insn[11:9];
        dec.r1re       = 1'b1;
        dec.regfile_we = 1'b1;
        dec.nzp_we     = 1'b1;
      end
      OP_TRAP: begin
        dec.wsel       = 3'd7;
        dec.regfile_we = 1'b1;
        dec.nzp_we     = 1'b1;
        dec.is_control = 1'b1;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/lc4_decode_stage.sv
// lc4_decode_stage: LC4 pipeline decode (D) stage.
// Holds the IF/D register, decodes the held instruction, detects load-use
// hazards against X and squashes on X-resolved mispredicts.
// Ports:
//   clk, rst (async, active-low), gwe (global write enable)
//   f_pc, f_insn, f_stall        : fetch-stage outputs
//   x_flush, x_is_load, x_wsel   : X-stage feedback
//   fetch_we                     : fetch PC register write enable
//   d_pc, d_insn, d_stall        : held IF/D register contents
//   d_r1sel/d_r2sel/d_wsel, d_r1re/d_r2re/d_regfile_we/d_nzp_we,
//   d_is_load/d_is_store/d_is_branch/d_is_control : decode of d_insn
//   x_bubble                     : X latches a NOP with stall code 3
//
// Stall contract: while x_bubble is high, fetch_we is low and D holds, so
// fetch and D both replay the same instruction next cycle; X takes a bubble
// instead of the D instruction. A hazard clears after one cycle because the
// load leaves X. A flush always wins over a stall and keeps fetch_we high
// so fetch can load the redirected PC.
module lc4_decode_stage
  import lc4_pkg::*;
#(
  parameter int                  WIDTH_PC = 16,
  parameter logic [WIDTH_PC-1:0] RST_PC   = '0,
  parameter logic [WIDTH_PC-1:0] NOP_INSN = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gwe,
  input  logic [WIDTH_PC-1:0] f_pc,
  input  logic [WIDTH_PC-1:0] f_insn,
  input  logic [1:0]          f_stall,
  input  logic                x_flush,
  input  logic                x_is_load,
  input  logic [2:0]          x_wsel,
  output logic                fetch_we,
  output logic [WIDTH_PC-1:0] d_pc,
  output logic [WIDTH_PC-1:0] d_insn,
  output logic [1:0]          d_stall,
  output logic [2:0]          d_r1sel,
  output logic [2:0]          d_r2sel,
  output logic [2:0]          d_wsel,
  output logic                d_r1re,
  output logic                d_r2re,
  output logic                d_regfile_we,
  output logic                d_nzp_we,
  output logic                d_is_load,
  output logic                d_is_store,
  output logic                d_is_branch,
  output logic                d_is_control,
  output logic                x_bubble
);

  decode_t dec_raw;
  decode_t dec;
  logic    is_bubble;
  logic    stall_ld;

  lc4_decoder u_decoder (
    .insn (d_insn[15:0]),
    .dec  (dec_raw)
  );

  // A bubble slot must not read, write or redirect anything.
  assign is_bubble = (d_stall != STALL_NONE);
  assign dec       = is_bubble ? squash(dec_raw) : dec_raw;

  // Store data is bypassed from M into the memory write, so an rt that is
  // only store data never needs to wait. Branches read nzp, which a load
  // in X has not produced yet.
  always_comb begin
    stall_ld = 1'b0;
    if (x_is_load && !x_flush && !is_bubble) begin
      stall_ld = (dec.r1re && (dec.r1sel == x_wsel))
               || (dec.r2re && !dec.is_store && (dec.r2sel == x_wsel))
               || dec.is_branch;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_pc    <= RST_PC;
      d_insn  <= NOP_INSN;
      d_stall <= STALL_FLUSH;
    end else if (gwe) begin
      if (x_flush) begin
        d_pc    <= f_pc;
        d_insn  <= NOP_INSN;
        d_stall <= STALL_FLUSH;
      end else if (!stall_ld) begin
        d_pc    <= f_pc;
        d_insn  <= f_insn;
        d_stall <= f_stall;
      end
    end
  end

  assign fetch_we     = ~stall_ld;
  assign x_bubble     = stall_ld;

  assign d_r1sel      = dec.r1sel;
  assign d_r2sel      = dec.r2sel;
  assign d_wsel       = dec.wsel;
  assign d_r1re       = dec.r1re;
  assign d_r2re       = dec.r2re;
  assign d_regfile_we = dec.regfile_we;
  assign d_nzp_we     = dec.nzp_we;
  assign d_is_load    = dec.is_load;
  assign d_is_store   = dec.is_store;
  assign d_is_branch  = dec.is_branch;
  assign d_is_control = dec.is_control;

endmodule

// File: tb/tb_lc4_decode_stage.sv
// Testbench for lc4_decode_stage: table-driven decode vectors, directed
// hazard/flush/gwe/reset sequences, and a randomized run checked against a
// behavioural model of the stage.
module tb_lc4_decode_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        gwe, x_flush, x_is_load;
  logic [15:0] f_pc, f_insn;
  logic [1:0]  f_stall;
  logic [2:0]  x_wsel;
  logic        fetch_we, x_bubble;
  logic [15:0] d_pc, d_insn;
  logic [1:0]  d_stall;
  logic [2:0]  d_r1sel, d_r2sel, d_wsel;
  logic        d_r1re, d_r2re, d_regfile_we, d_nzp_we;
  logic        d_is_load, d_is_store, d_is_branch, d_is_control;

  lc4_decode_stage dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .f_pc(f_pc), .f_insn(f_insn), .f_stall(f_stall),
    .x_flush(x_flush), .x_is_load(x_is_load), .x_wsel(x_wsel),
    .fetch_we(fetch_we), .d_pc(d_pc), .d_insn(d_insn), .d_stall(d_stall),
    .d_r1sel(d_r1sel), .d_r2sel(d_r2sel), .d_wsel(d_wsel),
    .d_r1re(d_r1re), .d_r2re(d_r2re), .d_regfile_we(d_regfile_we),
    .d_nzp_we(d_nzp_we), .d_is_load(d_is_load), .d_is_store(d_is_store),
    .d_is_branch(d_is_branch), .d_is_control(d_is_control),
    .x_bubble(x_bubble)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] obs_flags();
    return {d_r1re, d_r2re, d_regfile_we, d_nzp_we,
            d_is_load, d_is_store, d_is_branch, d_is_control};
  endfunction

  // Selects only matter where the matching enable is set.
  function automatic logic [8:0] mask_sels(input logic [7:0] fl, input logic [2:0] r1,
                                           input logic [2:0] r2, input logic [2:0] w);
    return {fl[7] ? r1 : 3'd0, fl[6] ? r2 : 3'd0, fl[5] ? w : 3'd0};
  endfunction

  // ---------------- reference model ----------------
  // flags = {r1re, r2re, regfile_we, nzp_we, is_load, is_store, is_branch, is_control}
  typedef struct packed {
    logic [2:0] r1, r2, w;
    logic [7:0] flags;
  } ref_dec_t;

  function automatic ref_dec_t ref_decode(input logic [15:0] i);
    ref_dec_t   d;
    logic [2:0] rd, rs, rt;
    rd = i[11:9]; rs = i[8:6]; rt = i[2:0];
    d = '0;
    case (i[15:12])
      4'h0: d.flags = (rd != 0) ? 8'b0000_0010 : 8'b0;
      4'h1: begin d.r1 = rs; d.r2 = rt; d.w = rd;
              d.flags = i[5] ? 8'b1011_0000 : 8'b1111_0000; end
      4'h2: begin d.r1 = rd; d.r2 = rt;
              d.flags = i[8] ? 8'b1001_0000 : 8'b1101_0000; end
      4'h4: begin d.r1 = rs; d.w = 3'd7;
              d.flags = i[11] ? 8'b0011_0001 : 8'b1011_0001; end
      4'h5: begin d.r1 = rs; d.r2 = rt; d.w = rd;
              d.flags = (i[5:3] == 3'b000 || i[5:3] == 3'b010 || i[5:3] == 3'b011)
                        ? 8'b1111_0000 : 8'b1011_0000; end
      4'h6: begin d.r1 = rs; d.w = rd; d.flags = 8'b1011_1000; end
      4'h7: begin d.r1 = rs; d.r2 = rd; d.flags = 8'b1100_0100; end
      4'h8: begin d.r1 = 3'd7; d.flags = 8'b1000_0001; end
      4'h9: begin d.w = rd; d.flags = 8'b0011_0000; end
      4'hA: begin d.r1 = rs; d.r2 = rt; d.w = rd;
              d.flags = (i[5:4] == 2'b11) ? 8'b1111_0000 : 8'b1011_0000; end
      4'hC: begin d.r1 = rs; d.flags = i[11] ? 8'b0000_0001 : 8'b1000_0001; end
      4'hD: begin d.r1 = rd; d.w = rd; d.flags = 8'b1011_0000; end
      4'hF: begin d.w = 3'd7; d.flags = 8'b0011_0001; end
      default: d = '0;
    endcase
    return d;
  endfunction

  logic [15:0] m_pc, m_insn;
  logic [1:0]  m_stall;

  function automatic ref_dec_t model_dec();
    ref_dec_t d;
    d = ref_decode(m_insn);
    if (m_stall != 2'd0) d.flags = 8'b0;
    return d;
  endfunction

  function automatic logic model_stall_ld();
    ref_dec_t d;
    d = model_dec();
    if (!x_is_load || x_flush || m_stall != 2'd0) return 1'b0;
    return (d.flags[7] && d.r1 == x_wsel)
        || (d.flags[6] && !d.flags[2] && d.r2 == x_wsel)
        || d.flags[1];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic g, input logic [15:0] pc, input logic [15:0] insn,
                       input logic [1:0] st, input logic fl, input logic ld,
                       input logic [2:0] ws);
    gwe = g; f_pc = pc; f_insn = insn; f_stall = st;
    x_flush = fl; x_is_load = ld; x_wsel = ws;
  endtask

  // One rising edge, then settle just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct packed {
    logic [15:0] insn;
    logic [2:0]  r1, r2, w;
    logic [7:0]  flags;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{16'h0000, 3'd0, 3'd0, 3'd0, 8'b0000_0000}; // NOP
    vecs[1]  = '{16'h0405, 3'd0, 3'd0, 3'd0, 8'b0000_0010}; // BRz
    vecs[2]  = '{16'h18C2, 3'd3, 3'd2, 3'd4, 8'b1111_0000}; // ADD R4,R3,R2
    vecs[3]  = '{16'h12A5, 3'd2, 3'd0, 3'd1, 8'b1011_0000}; // ADDI R1,R2,#5
    vecs[4]  = '{16'h2605, 3'd3, 3'd5, 3'd0, 8'b1101_0000}; // CMP R3,R5
    vecs[5]  = '{16'h2701, 3'd3, 3'd0, 3'd0, 8'b1001_0000}; // CMPI R3,#1
    vecs[6]  = '{16'h4080, 3'd2, 3'd0, 3'd7, 8'b1011_0001}; // JSRR R2
    vecs[7]  = '{16'h4805, 3'd0, 3'd0, 3'd7, 8'b0011_0001}; // JSR
    vecs[8]  = '{16'h5288, 3'd2, 3'd0, 3'd1, 8'b1011_0000}; // NOT R1,R2
    vecs[9]  = '{16'h529B, 3'd2, 3'd3, 3'd1, 8'b1111_0000}; // XOR R1,R2,R3
    vecs[10] = '{16'h6740, 3'd5, 3'd0, 3'd3, 8'b1011_1000}; // LDR R3,R5,#0
    vecs[11] = '{16'h7740, 3'd5, 3'd3, 3'd0, 8'b1100_0100}; // STR R3,R5,#0
    vecs[12] = '{16'h8000, 3'd7, 3'd0, 3'd0, 8'b1000_0001}; // RTI
    vecs[13] = '{16'h9201, 3'd0, 3'd0, 3'd1, 8'b0011_0000}; // CONST R1,#1
    vecs[14] = '{16'hA283, 3'd2, 3'd0, 3'd1, 8'b1011_0000}; // SLL R1,R2,#3
    vecs[15] = '{16'hA2B3, 3'd2, 3'd3, 3'd1, 8'b1111_0000}; // modulo R1,R2,R3
    vecs[16] = '{16'hC140, 3'd5, 3'd0, 3'd0, 8'b1000_0001}; // JMPR R5
    vecs[17] = '{16'hC805, 3'd0, 3'd0, 3'd0, 8'b0000_0001}; // JMP
    vecs[18] = '{16'hD501, 3'd2, 3'd0, 3'd2, 8'b1011_0000}; // HICONST R2
    vecs[19] = '{16'hF0FF, 3'd0, 3'd0, 3'd7, 8'b0011_0001}; // TRAP
    vecs[20] = '{16'h3123, 3'd0, 3'd0, 3'd0, 8'b0000_0000}; // undefined
    vecs[21] = '{16'hB123, 3'd0, 3'd0, 3'd0, 8'b0000_0000}; // undefined
    vecs[22] = '{16'hE123, 3'd0, 3'd0, 3'd0, 8'b0000_0000}; // undefined
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b0;
    drive(1'b1, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 3'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_d_pc",     d_pc,     64'h0);
    check("rst_d_insn",   d_insn,   64'h0);
    check("rst_d_stall",  d_stall,  64'd2);
    check("rst_fetch_we", fetch_we, 64'd1);
    check("rst_x_bubble", x_bubble, 64'd0);
    check("rst_flags",    obs_flags(), 64'd0);
    rst = 1'b1;

    // CONST R1,#1 enters D one cycle after being presented
    drive(1'b1, 16'h8200, 16'h9201, 2'd0, 1'b0, 1'b0, 3'd0);
    step();
    check("const_d_pc",     d_pc,         64'h8200);
    check("const_we",       d_regfile_we, 64'd1);
    check("const_wsel",     d_wsel,       64'd1);
    check("const_fetch_we", fetch_we,     64'd1);

    // Opcode sweep
    for (int k = 0; k < NV; k++) begin
      drive(1'b1, 16'h1000 + 16'(k), vecs[k].insn, 2'd0, 1'b0, 1'b0, 3'd0);
      step();
      check($sformatf("dec_flags_%0d", k), obs_flags(), vecs[k].flags);
      check($sformatf("dec_sels_%0d", k),
            mask_sels(vecs[k].flags, d_r1sel, d_r2sel, d_wsel),
            mask_sels(vecs[k].flags, vecs[k].r1, vecs[k].r2, vecs[k].w));
    end

    // Load-use on ADD R4,R3,R2 with LDR R3 in X: one-cycle stall
    drive(1'b1, 16'h0100, 16'h18C2, 2'd0, 1'b0, 1'b0, 3'd0);
    step();
    drive(1'b1, 16'h0101, 16'h9201, 2'd0, 1'b0, 1'b1, 3'd3);
    #1;
    check("lu_fetch_we", fetch_we, 64'd0);
    check("lu_x_bubble", x_bubble, 64'd1);
    step();
    check("lu_hold_insn", d_insn, 64'h18C2);
    check("lu_hold_pc",   d_pc,   64'h0100);
    drive(1'b1, 16'h0101, 16'h9201, 2'd0, 1'b0, 1'b0, 3'd0);
    #1;
    check("lu_release", {fetch_we, x_bubble}, 64'b10);
    step();
    check("lu_adv_insn", d_insn, 64'h9201);
    check("lu_adv_pc",   d_pc,   64'h0101);

    // STR with R3 as data: forwarded, no stall
    drive(1'b1, 16'h0200, 16'h7740, 2'd0, 1'b0, 1'b0, 3'd0);
    step();
    drive(1'b1, 16'h0201, 16'h0000, 2'd0, 1'b0, 1'b1, 3'd3);
    #1;
    check("str_data_nostall", x_bubble, 64'd0);
    // STR with R3 as base: stall
    drive(1'b1, 16'h0210, 16'h7AC0, 2'd0, 1'b0, 1'b0, 3'd0);
    step();
    drive(1'b1, 16'h0211, 16'h0000, 2'd0, 1'b0, 1'b1, 3'd3);
    #1;
    check("str_base_stall", {fetch_we, x_bubble}, 64'b01);

    // BRz behind a load stalls; a coincident flush wins
    drive(1'b1, 16'h0300, 16'h0405, 2'd0, 1'b0, 1'b0, 3'd0);
    step();
    drive(1'b1, 16'h0301, 16'h9201, 2'd0, 1'b0, 1'b1, 3'd0);
    #1;
    check("br_stall", x_bubble, 64'd1);
    drive(1'b1, 16'h0340, 16'h9201, 2'd0, 1'b1, 1'b1, 3'd0);
    #1;
    check("flush_nostall", {fetch_we, x_bubble}, 64'b10);
    step();
    check("flush_insn",  d_insn,      64'h0000);
    check("flush_stall", d_stall,     64'd2);
    check("flush_pc",    d_pc,        64'h0340);
    check("flush_flags", obs_flags(), 64'd0);

    // gwe=0 freezes the register while fetch inputs wander
    drive(1'b1, 16'h0400, 16'h18C2, 2'd0, 1'b0, 1'b0, 3'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0500 + 16'(k), 16'($urandom_range(0, 65535)), 2'd0, 1'b0, 1'b0, 3'd0);
      step();
      check($sformatf("gwe0_hold_%0d", k), {d_pc, d_insn}, {16'h0400, 16'h18C2});
    end
    check("gwe0_flags", obs_flags(), 64'b1111_0000);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 16'h0600, 16'h9201, 2'd0, 1'b0, 1'b1, 3'd2);
    #1;
    check("pre_rst_stall", x_bubble, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_regs", {d_pc, d_insn, 14'd0, d_stall}, {16'h0000, 16'h0000, 16'd2});
    check("async_rst_comb", {fetch_we, x_bubble}, 64'b10);

    // Randomized run against the model, starting from reset
    @(negedge clk);
    rst = 1'b1;
    m_pc = 16'h0; m_insn = 16'h0; m_stall = 2'd2;
    for (int n = 0; n < 400; n++) begin
      logic     exp_stall;
      ref_dec_t md;
      logic [1:0] st_pick [5];
      st_pick = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3};
      drive(($urandom_range(0, 7) != 0),
            16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)),
            st_pick[$urandom_range(0, 4)],
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) == 1),
            3'($urandom_range(0, 7)));
      #1;
      md        = model_dec();
      exp_stall = model_stall_ld();
      check($sformatf("rand_%0d", n),
            {d_pc, d_insn, d_stall, obs_flags(), fetch_we, x_bubble,
             mask_sels(md.flags, d_r1sel, d_r2sel, d_wsel)},
            {m_pc, m_insn, m_stall, md.flags, ~exp_stall, exp_stall,
             mask_sels(md.flags, md.r1, md.r2, md.w)});
      @(posedge clk);
      if (gwe) begin
        if (x_flush) begin
          m_pc = f_pc; m_insn = 16'h0000; m_stall = 2'd2;
        end else if (!exp_stall) begin
          m_pc = f_pc; m_insn = f_insn; m_stall = f_stall;
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
